priority_arbiter_n: RTL and testbench

- Parametrised, clocked successor to the PIC priority resolver.
- Resolves N interrupt levels against the mask and a registered in-service register (ISR) under fixed or rotating priority.
- Drives an interrupt-request / acknowledge handshake toward the CPU interface and owns the EOI and rotation commands.
- Sits between the interrupt request register logic and the control/bus interface of the PIC.

---
 rtl/priority_arbiter_n.sv | 198 +++++++++++++++++++
 tb/tb_priority_arbiter_n.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter_n.sv
`default_nettype none
//==============================================================================
// Module      : priority_arbiter_n
// Description : Clocked N-level interrupt priority resolver. It arbitrates
//               requests against the mask and the in-service register, using
//               fixed or rotating priority. It drives the INT/INTA handshake
//               and handles EOI and rotation commands.
// Revision    : 1.0  initial release
//==============================================================================
module priority_arbiter_n #(
    parameter  int N  = 8,
    localparam int LW = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [N-1:0]  irq_req,
    input  logic [N-1:0]  imr,
    input  logic          special_mask_mode,
    input  logic          auto_rotate,
    input  logic          int_ack,
    input  logic          eoi_cmd,
    input  logic          eoi_specific,
    input  logic          eoi_rotate,
    input  logic [LW-1:0] eoi_level,
    input  logic          set_priority,
    input  logic [LW-1:0] set_priority_level,
    output logic          int_out,
    output logic [LW-1:0] int_vec,
    output logic          int_vec_valid,
    output logic          spurious,
    output logic [N-1:0]  irr_clear,
    output logic [N-1:0]  isr,
    output logic [LW-1:0] lowest_prio
);

    localparam logic [N-1:0]  c_ONE        = N'(1);
    localparam logic [LW-1:0] c_LAST_LEVEL = LW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACKD = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_int_out;
    logic [LW-1:0] r_int_vec;
    logic          r_int_vec_valid;
    logic          r_spurious;
    logic [N-1:0]  r_irr_clear;
    logic [N-1:0]  r_isr;
    logic [LW-1:0] r_lowest_prio;

    logic [N-1:0]  w_eligible;
    logic [N-1:0]  w_block;
    logic          w_block_seen;
    logic          w_win_valid;
    logic [LW-1:0] w_win_level;
    logic          w_top_valid;
    logic [LW-1:0] w_top_level;
    logic [LW-1:0] w_lvl;
    logic          w_ack_fire;
    logic [N-1:0]  w_ack_set;
    logic [N-1:0]  w_eoi_clear;
    logic          w_rot_valid;
    logic [LW-1:0] w_rot_level;
    logic          w_sp_valid;

    // Level holding priority rank k (0 = highest) for a given lowest-priority pointer.
    function automatic logic [LW-1:0] level_at(input logic [LW-1:0] lp, input int k);
        int s;
        s = int'(lp) + 1 + k;
        if (s >= N) s = s - N;
        return LW'(s);
    endfunction

    assign w_eligible = irq_req & ~imr & ~r_isr;
    assign w_block    = special_mask_mode ? (r_isr & ~imr) : r_isr;

    // Walk the levels in priority order: first eligible level wins unless a blocking ISR bit comes first.
    always_comb begin
        w_block_seen = 1'b0;
        w_win_valid  = 1'b0;
        w_win_level  = '0;
        w_top_valid  = 1'b0;
        w_top_level  = '0;
        w_lvl        = '0;
        for (int k = 0; k < N; k++) begin
            w_lvl = level_at(r_lowest_prio, k);
            if (!w_block_seen && !w_win_valid) begin
                if (w_eligible[w_lvl]) begin
                    w_win_valid = 1'b1;
                    w_win_level = w_lvl;
                end else if (w_block[w_lvl]) begin
                    w_block_seen = 1'b1;
                end
            end
            if (!w_top_valid && r_isr[w_lvl]) begin
                w_top_valid = 1'b1;
                w_top_level = w_lvl;
            end
        end
    end

    // Ack sets the ISR bit of the sampled winner; a spurious ack sets nothing.
    assign w_ack_fire = (r_state == ST_REQ) && int_ack;
    assign w_ack_set  = (w_ack_fire && w_win_valid) ? (c_ONE << w_win_level) : '0;
    assign w_sp_valid = set_priority && (int'(set_priority_level) < N);

    // Decode the EOI command into an ISR clear mask and an optional rotation target.
    always_comb begin
        w_eoi_clear = '0;
        w_rot_valid = 1'b0;
        w_rot_level = '0;
        if (eoi_cmd) begin
            if (eoi_specific) begin
                if (int'(eoi_level) < N) begin
                    w_eoi_clear = c_ONE << eoi_level;
                    w_rot_valid = eoi_rotate;
                    w_rot_level = eoi_level;
                end
            end else if (w_top_valid) begin
                w_eoi_clear = c_ONE << w_top_level;
                w_rot_valid = eoi_rotate || auto_rotate;
                w_rot_level = w_top_level;
            end
        end
    end

    // ISR and priority pointer; ack set beats EOI clear, set_priority beats rotation.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_isr         <= '0;
            r_lowest_prio <= c_LAST_LEVEL;
        end else begin
            r_isr <= (r_isr & ~w_eoi_clear) | w_ack_set;
            if (w_sp_valid) begin
                r_lowest_prio <= set_priority_level;
            end else if (w_rot_valid) begin
                r_lowest_prio <= w_rot_level;
            end
        end
    end

    // Handshake FSM with registered request, vector and pulse outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_int_out       <= 1'b0;
            r_int_vec       <= '0;
            r_int_vec_valid <= 1'b0;
            r_spurious      <= 1'b0;
            r_irr_clear     <= '0;
        end else begin
            r_int_vec_valid <= 1'b0;
            r_spurious      <= 1'b0;
            r_irr_clear     <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_state   <= ST_REQ;
                        r_int_out <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        r_state         <= ST_ACKD;
                        r_int_out       <= 1'b0;
                        r_int_vec_valid <= 1'b1;
                        r_spurious      <= !w_win_valid;
                        r_int_vec       <= w_win_valid ? w_win_level : c_LAST_LEVEL;
                        r_irr_clear     <= w_ack_set;
                    end else if (!w_win_valid) begin
                        r_state   <= ST_IDLE;
                        r_int_out <= 1'b0;
                    end
                end
                ST_ACKD: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_int_out <= 1'b0;
                end
            endcase
        end
    end

    assign int_out       = r_int_out;
    assign int_vec       = r_int_vec;
    assign int_vec_valid = r_int_vec_valid;
    assign spurious      = r_spurious;
    assign irr_clear     = r_irr_clear;
    assign isr           = r_isr;
    assign lowest_prio   = r_lowest_prio;

endmodule
`default_nettype wire

// File: tb/tb_priority_arbiter_n.sv
`default_nettype none
//==============================================================================
// Module      : tb_priority_arbiter_n
// Description : Directed self-checking bench for priority_arbiter_n with
//               N=8 (main scenarios), N=16 (wider pointer) and N=12
//               (out-of-range level commands).
// Revision    : 1.0  initial release
//==============================================================================
module tb_priority_arbiter_n;

    logic clock;
    logic reset_n;
    int   tests    = 0;
    int   failures = 0;

    // N = 8 instance
    logic [7:0] a_irq, a_imr, a_irrc, a_isr;
    logic       a_smm, a_ar, a_ack, a_eoi, a_eoi_spec, a_eoi_rot, a_sp;
    logic [2:0] a_eoi_lvl, a_sp_lvl, a_vec, a_lp;
    logic       a_int_out, a_vld, a_spur;

    // N = 16 instance
    logic [15:0] b_irq, b_imr, b_irrc, b_isr;
    logic        b_smm, b_ar, b_ack, b_eoi, b_eoi_spec, b_eoi_rot, b_sp;
    logic [3:0]  b_eoi_lvl, b_sp_lvl, b_vec, b_lp;
    logic        b_int_out, b_vld, b_spur;

    // N = 12 instance
    logic [11:0] c_irq, c_imr, c_irrc, c_isr;
    logic        c_smm, c_ar, c_ack, c_eoi, c_eoi_spec, c_eoi_rot, c_sp;
    logic [3:0]  c_eoi_lvl, c_sp_lvl, c_vec, c_lp;
    logic        c_int_out, c_vld, c_spur;

    priority_arbiter_n #(.N(8)) u_dut8 (
        .clock(clock), .reset_n(reset_n), .irq_req(a_irq), .imr(a_imr),
        .special_mask_mode(a_smm), .auto_rotate(a_ar), .int_ack(a_ack),
        .eoi_cmd(a_eoi), .eoi_specific(a_eoi_spec), .eoi_rotate(a_eoi_rot),
        .eoi_level(a_eoi_lvl), .set_priority(a_sp), .set_priority_level(a_sp_lvl),
        .int_out(a_int_out), .int_vec(a_vec), .int_vec_valid(a_vld),
        .spurious(a_spur), .irr_clear(a_irrc), .isr(a_isr), .lowest_prio(a_lp)
    );

    priority_arbiter_n #(.N(16)) u_dut16 (
        .clock(clock), .reset_n(reset_n), .irq_req(b_irq), .imr(b_imr),
        .special_mask_mode(b_smm), .auto_rotate(b_ar), .int_ack(b_ack),
        .eoi_cmd(b_eoi), .eoi_specific(b_eoi_spec), .eoi_rotate(b_eoi_rot),
        .eoi_level(b_eoi_lvl), .set_priority(b_sp), .set_priority_level(b_sp_lvl),
        .int_out(b_int_out), .int_vec(b_vec), .int_vec_valid(b_vld),
        .spurious(b_spur), .irr_clear(b_irrc), .isr(b_isr), .lowest_prio(b_lp)
    );

    priority_arbiter_n #(.N(12)) u_dut12 (
        .clock(clock), .reset_n(reset_n), .irq_req(c_irq), .imr(c_imr),
        .special_mask_mode(c_smm), .auto_rotate(c_ar), .int_ack(c_ack),
        .eoi_cmd(c_eoi), .eoi_specific(c_eoi_spec), .eoi_rotate(c_eoi_rot),
        .eoi_level(c_eoi_lvl), .set_priority(c_sp), .set_priority_level(c_sp_lvl),
        .int_out(c_int_out), .int_vec(c_vec), .int_vec_valid(c_vld),
        .spurious(c_spur), .irr_clear(c_irrc), .isr(c_isr), .lowest_prio(c_lp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        a_irq = '0; a_imr = '0; a_smm = 0; a_ar = 0; a_ack = 0; a_eoi = 0;
        a_eoi_spec = 0; a_eoi_rot = 0; a_eoi_lvl = '0; a_sp = 0; a_sp_lvl = '0;
        b_irq = '0; b_imr = '0; b_smm = 0; b_ar = 0; b_ack = 0; b_eoi = 0;
        b_eoi_spec = 0; b_eoi_rot = 0; b_eoi_lvl = '0; b_sp = 0; b_sp_lvl = '0;
        c_irq = '0; c_imr = '0; c_smm = 0; c_ar = 0; c_ack = 0; c_eoi = 0;
        c_eoi_spec = 0; c_eoi_rot = 0; c_eoi_lvl = '0; c_sp = 0; c_sp_lvl = '0;
        tick();
        tick();

        // Reset state
        check("rst_int_out", a_int_out, 0);
        check("rst_isr", a_isr, 8'h00);
        check("rst_lp8", a_lp, 7);
        check("rst_vld", a_vld, 0);
        check("rst_vec", a_vec, 0);
        check("rst_lp16", b_lp, 15);
        check("rst_lp12", c_lp, 11);
        reset_n = 1'b1;
        tick();

        // 1: levels 2 and 3 request; level 2 wins, level 3 is held off by isr[2]
        a_irq = 8'h0C;
        tick();
        check("t1_int_out_rise", a_int_out, 1);
        a_ack = 1;
        tick();
        a_ack = 0;
        check("t1_vec", a_vec, 2);
        check("t1_vld", a_vld, 1);
        check("t1_spur", a_spur, 0);
        check("t1_isr", a_isr, 8'h04);
        check("t1_irrc", a_irrc, 8'h04);
        check("t1_int_out_low", a_int_out, 0);
        tick();
        check("t1_vld_pulse", a_vld, 0);
        check("t1_irrc_pulse", a_irrc, 8'h00);
        tick();
        check("t1_lvl3_held", a_int_out, 0);

        // 2: non-specific EOI with auto rotate -> pointer to 2, level 3 now highest
        a_ar = 1; a_eoi = 1; a_eoi_spec = 0;
        tick();
        a_eoi = 0; a_ar = 0;
        check("t2_isr", a_isr, 8'h00);
        check("t2_lp", a_lp, 2);
        a_irq = 8'h0D;
        tick();
        check("t2_int_out", a_int_out, 1);
        a_ack = 1;
        tick();
        a_ack = 0;
        check("t2_vec", a_vec, 3);
        check("t2_isr_after", a_isr, 8'h08);
        tick();

        // 3: restore fixed priority, put level 0 in service, then special mask mode
        a_sp = 1; a_sp_lvl = 3'd7; a_eoi = 1; a_eoi_spec = 1; a_eoi_lvl = 3'd3;
        tick();
        a_sp = 0; a_eoi = 0; a_eoi_spec = 0;
        check("t3_lp", a_lp, 7);
        check("t3_isr_clr", a_isr, 8'h00);
        a_irq = 8'h01;
        tick();
        a_ack = 1;
        tick();
        a_ack = 0;
        check("t3_vec0", a_vec, 0);
        check("t3_isr0", a_isr, 8'h01);
        a_imr = 8'h01; a_irq = 8'h20; a_smm = 0;
        tick();
        tick();
        tick();
        check("t3_smm0_blocked", a_int_out, 0);
        a_smm = 1;
        tick();
        check("t3_smm1_int_out", a_int_out, 1);
        a_ack = 1;
        tick();
        a_ack = 0;
        check("t3_vec5", a_vec, 5);
        check("t3_isr", a_isr, 8'h21);

        // 4: request withdrawn on the ack cycle -> spurious
        a_smm = 0; a_imr = 8'h00; a_irq = 8'h00;
        a_eoi = 1; a_eoi_spec = 1; a_eoi_lvl = 3'd0;
        tick();
        a_eoi_lvl = 3'd5;
        tick();
        a_eoi = 0; a_eoi_spec = 0;
        check("t4_isr_clr", a_isr, 8'h00);
        a_irq = 8'h40;
        tick();
        check("t4_int_out", a_int_out, 1);
        a_ack = 1; a_irq = 8'h00;
        tick();
        a_ack = 0;
        check("t4_vld", a_vld, 1);
        check("t4_spur", a_spur, 1);
        check("t4_vec", a_vec, 7);
        check("t4_isr", a_isr, 8'h00);
        check("t4_irrc", a_irrc, 8'h00);
        tick();
        // winner lost without ack drops the request
        a_irq = 8'h40;
        tick();
        check("t4b_int_out", a_int_out, 1);
        a_irq = 8'h00;
        tick();
        check("t4b_drop", a_int_out, 0);
        // ack outside REQ is ignored
        a_ack = 1;
        tick();
        a_ack = 0;
        check("t4c_ack_idle", a_vld, 0);

        // 5: set_priority overrides rotation from a specific EOI in the same cycle
        a_irq = 8'h02;
        tick();
        a_ack = 1;
        tick();
        a_ack = 0; a_irq = 8'h00;
        check("t5_isr_set", a_isr, 8'h02);
        tick();
        a_sp = 1; a_sp_lvl = 3'd4;
        a_eoi = 1; a_eoi_spec = 1; a_eoi_rot = 1; a_eoi_lvl = 3'd1;
        tick();
        a_sp = 0; a_eoi = 0; a_eoi_spec = 0; a_eoi_rot = 0;
        check("t5_isr", a_isr, 8'h00);
        check("t5_lp", a_lp, 4);
        // ack set wins over a same-cycle EOI on the same bit
        a_irq = 8'h01;
        tick();
        a_ack = 1; a_eoi = 1; a_eoi_spec = 1; a_eoi_lvl = 3'd0;
        tick();
        a_ack = 0; a_eoi = 0; a_eoi_spec = 0; a_irq = 8'h00;
        check("t5_ack_beats_eoi", a_isr, 8'h01);

        // Out-of-range levels on N=12 are ignored
        c_sp = 1; c_sp_lvl = 4'd13;
        tick();
        check("r_sp13_ignored", c_lp, 11);
        c_sp_lvl = 4'd9;
        tick();
        c_sp = 0;
        check("r_sp9", c_lp, 9);
        c_eoi = 1; c_eoi_spec = 1; c_eoi_rot = 1; c_eoi_lvl = 4'd14;
        tick();
        c_eoi = 0; c_eoi_spec = 0; c_eoi_rot = 0;
        check("r_eoi14_ignored", c_lp, 9);

        // 6: N=16, level 0 over 15 by default, then 15 over 0 after pointer moves to 0
        b_irq = 16'h8001;
        tick();
        b_ack = 1;
        tick();
        b_ack = 0;
        check("t6_vec0", b_vec, 0);
        b_eoi = 1; b_eoi_spec = 1; b_eoi_lvl = 4'd0; b_sp = 1; b_sp_lvl = 4'd0;
        tick();
        b_eoi = 0; b_eoi_spec = 0; b_sp = 0;
        check("t6_lp0", b_lp, 0);
        tick();
        b_ack = 1;
        tick();
        b_ack = 0;
        check("t6_vec15", b_vec, 15);
        b_eoi = 1; b_eoi_spec = 1; b_eoi_lvl = 4'd15; b_irq = 16'h8003;
        tick();
        b_eoi = 0; b_eoi_spec = 0;
        tick();
        b_ack = 1;
        tick();
        b_ack = 0;
        check("t6_vec1", b_vec, 1);

        // Reset mid-handshake discards the pending ack
        a_irq = 8'h40;
        tick();
        tick();
        check("rm_int_out", a_int_out, 1);
        reset_n = 1'b0; a_ack = 1;
        tick();
        a_ack = 0;
        check("rm_vld", a_vld, 0);
        check("rm_int_out_low", a_int_out, 0);
        check("rm_isr", a_isr, 8'h00);
        check("rm_lp", a_lp, 7);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
`default_nettype wire
